// File: rtl/clk_pkg.sv
// Shared widths, limits and set-mode encodings for the wall-clock time keeper.
package clk_pkg;

  localparam int unsigned SEC_W    = 6;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned HOUR_W   = 5;
  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10
  } set_state_e;

  // 24-hour value to 12-hour display value (0 and 12 both show as 12)
  function automatic logic [HOUR_W-1:0] to_hour12(input logic [HOUR_W-1:0] h24);
    logic [HOUR_W-1:0] h;
    h = (h24 >= HOUR_W'(12)) ? h24 - HOUR_W'(12) : h24;
    return (h == '0) ? HOUR_W'(12) : h;
  endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Button/1 Hz inputs and time outputs of the time keeper, bundled for the display stage.
interface time_keeper_if;
  import clk_pkg::*;

  logic              sig_1Hz;
  logic              mode_btn;
  logic              inc_btn;
  logic [SEC_W-1:0]  sec;
  logic [MIN_W-1:0]  min;
  logic [HOUR_W-1:0] hour;
  logic              pm;
  logic [1:0]        set_state;
  logic              sec_tick;

  modport master (
    output sig_1Hz, mode_btn, inc_btn,
    input  sec, min, hour, pm, set_state, sec_tick
  );

  modport slave (
    input  sig_1Hz, mode_btn, inc_btn,
    output sec, min, hour, pm, set_state, sec_tick
  );

endinterface

// File: rtl/rise_det.sv
// Two-register sampler with a rising-edge pulse taken between the two stages.
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise_c
);

  logic r_q0;
  logic r_q1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q0 <= 1'b0;
      r_q1 <= 1'b0;
    end else begin
      r_q0 <= i_sig;
      r_q1 <= r_q0;
    end
  end

  assign o_rise_c = r_q0 & ~r_q1;

endmodule

// File: rtl/time_keeper.sv
// hh:mm:ss wall clock advanced by sig_1Hz rises, with hour/minute set mode.
// Optional HOUR12_EN maps the internal 24-hour count to a 1..12 hour plus pm flag.
module time_keeper
  import clk_pkg::*;
#(
  parameter int unsigned INIT_HOUR = 0,
  parameter int unsigned INIT_MIN  = 0
) (
  input  logic          clk_50MHz,
  input  logic          reset_n,
  time_keeper_if.slave  bus
);

  logic w_tick_rise;
  logic w_mode_rise;
  logic w_inc_rise;

  rise_det u_rise_1hz (
    .clk      (clk_50MHz),
    .rst_n    (reset_n),
    .i_sig    (bus.sig_1Hz),
    .o_rise_c (w_tick_rise)
  );

  rise_det u_rise_mode (
    .clk      (clk_50MHz),
    .rst_n    (reset_n),
    .i_sig    (bus.mode_btn),
    .o_rise_c (w_mode_rise)
  );

  rise_det u_rise_inc (
    .clk      (clk_50MHz),
    .rst_n    (reset_n),
    .i_sig    (bus.inc_btn),
    .o_rise_c (w_inc_rise)
  );

  set_state_e        r_state;
  logic [SEC_W-1:0]  r_sec;
  logic [MIN_W-1:0]  r_min;
  logic [HOUR_W-1:0] r_h24;
  logic              r_sec_tick;

  logic [SEC_W-1:0]  w_sec_nxt;
  logic [MIN_W-1:0]  w_min_nxt;
  logic [HOUR_W-1:0] w_h24_nxt;
  logic              w_tick_nxt;

  // Counter next values; a mode rise pre-empts any tick or inc in the same cycle
  always_comb begin
    w_sec_nxt  = r_sec;
    w_min_nxt  = r_min;
    w_h24_nxt  = r_h24;
    w_tick_nxt = 1'b0;
    if (w_mode_rise) begin
      if (r_state == ST_RUN) w_sec_nxt = '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_tick_rise) begin
            w_tick_nxt = 1'b1;
            if (r_sec == SEC_W'(SEC_MAX)) begin
              w_sec_nxt = '0;
              if (r_min == MIN_W'(MIN_MAX)) begin
                w_min_nxt = '0;
                w_h24_nxt = (r_h24 == HOUR_W'(HOUR_MAX)) ? '0 : r_h24 + HOUR_W'(1);
              end else begin
                w_min_nxt = r_min + MIN_W'(1);
              end
            end else begin
              w_sec_nxt = r_sec + SEC_W'(1);
            end
          end
        end
        ST_SET_HOUR: begin
          if (w_inc_rise)
            w_h24_nxt = (r_h24 == HOUR_W'(HOUR_MAX)) ? '0 : r_h24 + HOUR_W'(1);
        end
        ST_SET_MIN: begin
          if (w_inc_rise)
            w_min_nxt = (r_min == MIN_W'(MIN_MAX)) ? '0 : r_min + MIN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Set-mode FSM and time registers
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_RUN;
      r_sec      <= '0;
      r_min      <= MIN_W'(INIT_MIN);
      r_h24      <= HOUR_W'(INIT_HOUR);
      r_sec_tick <= 1'b0;
    end else begin
      if (w_mode_rise) begin
        case (r_state)
          ST_RUN:      r_state <= ST_SET_HOUR;
          ST_SET_HOUR: r_state <= ST_SET_MIN;
          default:     r_state <= ST_RUN;
        endcase
      end
      r_sec      <= w_sec_nxt;
      r_min      <= w_min_nxt;
      r_h24      <= w_h24_nxt;
      r_sec_tick <= w_tick_nxt;
    end
  end

`ifdef HOUR12_EN
  logic [HOUR_W-1:0] r_hour;
  logic              r_pm;

  // Display mapping registered from the next 24-hour value so it tracks r_h24 exactly
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_hour <= to_hour12(HOUR_W'(INIT_HOUR));
      r_pm   <= (INIT_HOUR >= 12);
    end else begin
      r_hour <= to_hour12(w_h24_nxt);
      r_pm   <= (w_h24_nxt >= HOUR_W'(12));
    end
  end

  assign bus.hour = r_hour;
  assign bus.pm   = r_pm;
`else
  assign bus.hour = r_h24;
  assign bus.pm   = 1'b0;
`endif

  assign bus.sec       = r_sec;
  assign bus.min       = r_min;
  assign bus.set_state = r_state;
  assign bus.sec_tick  = r_sec_tick;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: counting, carries, set mode, edge priority and reset.
module tb_time_keeper;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [2:0] pat;

  time_keeper_if bus ();

  time_keeper #(
    .INIT_HOUR (0),
    .INIT_MIN  (0)
  ) dut (
    .clk_50MHz (clk),
    .reset_n   (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_hour(input int h24);
`ifdef HOUR12_EN
    return (h24 % 12 == 0) ? 12 : h24 % 12;
`else
    return h24;
`endif
  endfunction

  function automatic int exp_pm(input int h24);
`ifdef HOUR12_EN
    return (h24 >= 12) ? 1 : 0;
`else
    return (h24 < 0) ? 1 : 0;
`endif
  endfunction

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hour"}, 32'(bus.hour), 32'(exp_hour(h)));
    check({tag, ".min"},  32'(bus.min),  32'(m));
    check({tag, ".sec"},  32'(bus.sec),  32'(s));
  endtask

  // Called at a negedge; pat = sec_tick at the 1st, 2nd, 3rd negedge after the rise
  task automatic do_tick(output logic [2:0] p);
    bus.sig_1Hz = 1'b1;
    @(negedge clk) p[2] = bus.sec_tick;
    @(negedge clk) p[1] = bus.sec_tick;
    @(negedge clk) p[0] = bus.sec_tick;
    bus.sig_1Hz = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input logic m, input logic i, input int hold);
    bus.mode_btn = m;
    bus.inc_btn  = i;
    repeat (hold) @(negedge clk);
    bus.mode_btn = 1'b0;
    bus.inc_btn  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) press(1'b0, 1'b1, 2);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.sig_1Hz  = 1'b0;
    bus.mode_btn = 1'b0;
    bus.inc_btn  = 1'b0;

    // 1) reset state
    repeat (3) @(negedge clk);
    check_time("rst_low", 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_time("rst_rel", 0, 0, 0);
    check("rst.state", 32'(bus.set_state), 32'd0);
    check("rst.tick",  32'(bus.sec_tick),  32'd0);
    check("rst.pm",    32'(bus.pm),        32'(exp_pm(0)));

    // 2) 60 seconds carry into minutes; tick pulse shape per rise
    for (int k = 0; k < 60; k++) begin
      do_tick(pat);
      check("tick_pulse", 32'(pat), 32'b010);
    end
    check_time("min_carry", 0, 1, 0);
    press(1'b0, 1'b1, 3);
    check("run_inc.min",   32'(bus.min),       32'd1);
    check("run_inc.state", 32'(bus.set_state), 32'd0);

    // 4) hour set wraps at 24, minute set wraps at 60 without hour carry
    press(1'b1, 1'b0, 3);
    check("set_hour.state", 32'(bus.set_state), 32'd1);
    incs(25);
    check("set_hour.h", 32'(bus.hour), 32'(exp_hour(1)));
    do_tick(pat);
    check("set_tick.pat", 32'(pat), 32'b000);
    do_tick(pat);
    check("set_tick.sec", 32'(bus.sec), 32'd0);
    press(1'b1, 1'b0, 3);
    check("set_min.state", 32'(bus.set_state), 32'd2);
    incs(61);
    check_time("set_min", 1, 2, 0);
    press(1'b1, 1'b0, 3);
    check("back_run.state", 32'(bus.set_state), 32'd0);
    do_tick(pat);
    check("back_run.pat", 32'(pat), 32'b010);
    check_time("back_run", 1, 2, 1);

    // 3) preload 23:59:59 then full wrap
    press(1'b1, 1'b0, 3);
    check("enter_set.sec", 32'(bus.sec), 32'd0);
    incs(22);
    press(1'b1, 1'b0, 3);
    incs(57);
    press(1'b1, 1'b0, 3);
    for (int k = 0; k < 59; k++) do_tick(pat);
    check_time("preload", 23, 59, 59);
    check("preload.pm", 32'(bus.pm), 32'(exp_pm(23)));
    do_tick(pat);
    check("wrap.pat", 32'(pat), 32'b010);
    check_time("wrap", 0, 0, 0);
    check("wrap.pm", 32'(bus.pm), 32'(exp_pm(0)));
    press(1'b1, 1'b0, 3);
    incs(12);
    press(1'b1, 1'b0, 3);
    press(1'b1, 1'b0, 3);
    check("noon.state", 32'(bus.set_state), 32'd0);
    check_time("noon", 12, 0, 0);
    check("noon.pm", 32'(bus.pm), 32'(exp_pm(12)));

    // 5) simultaneous mode+inc: mode wins; held inc acts once
    press(1'b1, 1'b1, 3);
    check("simul.state", 32'(bus.set_state), 32'd1);
    check("simul.hour",  32'(bus.hour),      32'(exp_hour(12)));
    press(1'b1, 1'b0, 3);
    press(1'b0, 1'b1, 10);
    check("held_inc.min", 32'(bus.min), 32'd1);
    check("held_inc.state", 32'(bus.set_state), 32'd2);

    // 6) reset mid SET_MIN is immediate and discards the partial setting
    rst_n = 1'b0;
    #2;
    check("mid_rst.state", 32'(bus.set_state), 32'd0);
    check("mid_rst.tick",  32'(bus.sec_tick),  32'd0);
    check_time("mid_rst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst.state", 32'(bus.set_state), 32'd0);
    check_time("post_rst", 0, 0, 0);
    do_tick(pat);
    check("post_rst.pat", 32'(pat), 32'b010);
    check("post_rst.sec", 32'(bus.sec), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
